// File: rtl/mc_control_pkg.sv
// Shared constants for the multicycle controller and its datapath:
// opcodes, FSM state encodings and mux-select codes.
package mc_control_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_JAL      = 4'd12
  } state_t;

  localparam logic [1:0] SRC_B_REG     = 2'd0;
  localparam logic [1:0] SRC_B_FOUR    = 2'd1;
  localparam logic [1:0] SRC_B_IMM     = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;

  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

endpackage

// File: rtl/mc_control_if.sv
// Control bundle between the multicycle controller (master) and the
// datapath (slave): decode inputs, memory handshake and all selects/enables.
interface mc_control_if;

  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       i_or_d;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic [1:0] pc_source;
  logic [1:0] alu_op;
  logic       illegal;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, ir_write, mem_read, mem_write, reg_write, i_or_d,
           alu_src_a, alu_src_b, reg_dst, mem_to_reg, pc_source, alu_op,
           illegal
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, ir_write, mem_read, mem_write, reg_write, i_or_d,
           alu_src_a, alu_src_b, reg_dst, mem_to_reg, pc_source, alu_op,
           illegal
  );

endinterface

// File: rtl/mc_control.sv
// Multicycle MIPS-subset controller: Moore FSM sequencing fetch, decode,
// execute, memory and write-back, plus a sticky illegal-opcode flag.
//
//   state    | meaning
//   FETCH    | read instruction at PC, PC+4; hold until mem_ready
//   DECODE   | branch target into ALUOut, dispatch on opcode
//   MEM_ADDR | base + imm address for lw/sw
//   MEM_RD   | data read, hold until mem_ready
//   MEM_WB   | MDR -> rt
//   MEM_WR   | data write, hold until mem_ready
//   EXEC     | R-type ALU operation
//   R_WB     | ALUOut -> rd
//   BRANCH   | compare, PC <- ALUOut if zero
//   JUMP     | PC <- jump target
//   ADDI_EX  | reg A + imm
//   ADDI_WB  | ALUOut -> rt
//   JAL      | PC <- jump target, PC -> $31
module mc_control
  import mc_control_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  mc_control_if.master bus
);

  state_t state;
  state_t state_nxt;
  logic   illegal_q;
  logic   illegal_set;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (illegal_set) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt      = state;
    illegal_set    = 1'b0;
    bus.pc_write   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.reg_write  = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = SRC_B_REG;
    bus.reg_dst    = REG_DST_RT;
    bus.mem_to_reg = M2R_ALUOUT;
    bus.pc_source  = PC_SRC_ALU;
    bus.alu_op     = ALU_ADD;
    bus.illegal    = illegal_q;

    // Outputs are gated by reset itself so a mid-wait request drops at once.
    if (reset_n) begin
      case (state)
        S_FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = SRC_B_FOUR;
          bus.ir_write  = bus.mem_ready;
          bus.pc_write  = bus.mem_ready;
          if (bus.mem_ready) state_nxt = S_DECODE;
        end
        S_DECODE: begin
          bus.alu_src_b = SRC_B_IMM_SH2;
          case (bus.opcode)
            OP_R:         state_nxt = S_EXEC;
            OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
            OP_BEQ:       state_nxt = S_BRANCH;
            OP_J:         state_nxt = S_JUMP;
            OP_ADDI:      state_nxt = S_ADDI_EX;
            OP_JAL:       state_nxt = S_JAL;
            default: begin
              state_nxt   = S_FETCH;
              illegal_set = 1'b1;
            end
          endcase
        end
        S_MEM_ADDR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = SRC_B_IMM;
          if (bus.opcode == OP_LW)      state_nxt = S_MEM_RD;
          else if (bus.opcode == OP_SW) state_nxt = S_MEM_WR;
          else                          state_nxt = S_FETCH;
        end
        S_MEM_RD: begin
          bus.mem_read = 1'b1;
          bus.i_or_d   = 1'b1;
          if (bus.mem_ready) state_nxt = S_MEM_WB;
        end
        S_MEM_WB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = M2R_MDR;
          state_nxt      = S_FETCH;
        end
        S_MEM_WR: begin
          bus.mem_write = 1'b1;
          bus.i_or_d    = 1'b1;
          if (bus.mem_ready) state_nxt = S_FETCH;
        end
        S_EXEC: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = ALU_FUNCT;
          state_nxt     = S_R_WB;
        end
        S_R_WB: begin
          bus.reg_write = 1'b1;
          bus.reg_dst   = REG_DST_RD;
          state_nxt     = S_FETCH;
        end
        S_BRANCH: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = ALU_SUB;
          bus.pc_source = PC_SRC_ALUOUT;
          bus.pc_write  = bus.zero;
          state_nxt     = S_FETCH;
        end
        S_JUMP: begin
          bus.pc_source = PC_SRC_JUMP;
          bus.pc_write  = 1'b1;
          state_nxt     = S_FETCH;
        end
        S_ADDI_EX: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = SRC_B_IMM;
          state_nxt     = S_ADDI_WB;
        end
        S_ADDI_WB: begin
          bus.reg_write = 1'b1;
          state_nxt     = S_FETCH;
        end
        S_JAL: begin
          bus.pc_source  = PC_SRC_JUMP;
          bus.pc_write   = 1'b1;
          bus.reg_write  = 1'b1;
          bus.reg_dst    = REG_DST_RA;
          bus.mem_to_reg = M2R_PC;
          state_nxt      = S_FETCH;
        end
        default: state_nxt = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: per-cycle control-word checks for every
// instruction class, memory stalls, illegal opcode and mid-wait reset.
module tb_mc_control;
  import mc_control_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  mc_control_if bus ();

  mc_control dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  // {pc_write, ir_write, mem_read, mem_write, reg_write, i_or_d, alu_src_a,
  //  alu_src_b, reg_dst, mem_to_reg, pc_source, alu_op}
  logic [16:0] ctl;
  assign ctl = {bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write,
                bus.reg_write, bus.i_or_d, bus.alu_src_a, bus.alu_src_b,
                bus.reg_dst, bus.mem_to_reg, bus.pc_source, bus.alu_op};

  localparam logic [16:0] E_ZERO    = 17'b0_0_0_0_0_0_0_00_00_00_00_00;
  localparam logic [16:0] E_FETCH_W = 17'b0_0_1_0_0_0_0_01_00_00_00_00;
  localparam logic [16:0] E_FETCH_R = 17'b1_1_1_0_0_0_0_01_00_00_00_00;
  localparam logic [16:0] E_DECODE  = 17'b0_0_0_0_0_0_0_11_00_00_00_00;
  localparam logic [16:0] E_MEMADDR = 17'b0_0_0_0_0_0_1_10_00_00_00_00;
  localparam logic [16:0] E_MEMRD   = 17'b0_0_1_0_0_1_0_00_00_00_00_00;
  localparam logic [16:0] E_MEMWB   = 17'b0_0_0_0_1_0_0_00_00_01_00_00;
  localparam logic [16:0] E_MEMWR   = 17'b0_0_0_1_0_1_0_00_00_00_00_00;
  localparam logic [16:0] E_EXEC    = 17'b0_0_0_0_0_0_1_00_00_00_00_10;
  localparam logic [16:0] E_RWB     = 17'b0_0_0_0_1_0_0_00_01_00_00_00;
  localparam logic [16:0] E_BR_Z1   = 17'b1_0_0_0_0_0_1_00_00_00_01_01;
  localparam logic [16:0] E_BR_Z0   = 17'b0_0_0_0_0_0_1_00_00_00_01_01;
  localparam logic [16:0] E_JUMP    = 17'b1_0_0_0_0_0_0_00_00_00_10_00;
  localparam logic [16:0] E_ADDIEX  = 17'b0_0_0_0_0_0_1_10_00_00_00_00;
  localparam logic [16:0] E_ADDIWB  = 17'b0_0_0_0_1_0_0_00_00_00_00_00;
  localparam logic [16:0] E_JAL     = 17'b1_0_0_0_1_0_0_00_10_10_10_00;

  task automatic test_reset();
    reset_n       = 1'b0;
    bus.opcode    = OP_R;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (ctl !== E_ZERO) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b", ctl, E_ZERO);
    end
    checks++;
    if (bus.illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_illegal: got %b want 0", bus.illegal);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_r_type();
    logic [16:0] exp [4] = '{E_FETCH_R, E_DECODE, E_EXEC, E_RWB};
    bus.opcode    = OP_R;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (ctl !== exp[i]) begin
        errors++;
        $display("FAIL r_type cyc%0d: got %b want %b", i, ctl, exp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lw_wait();
    logic [16:0] exp [8] = '{E_FETCH_R, E_DECODE, E_MEMADDR, E_MEMRD,
                             E_MEMRD, E_MEMRD, E_MEMRD, E_MEMWB};
    logic        rdy [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bus.opcode = OP_LW;
    for (int i = 0; i < 8; i++) begin
      bus.mem_ready = rdy[i];
      #1;
      checks++;
      if (ctl !== exp[i]) begin
        errors++;
        $display("FAIL lw_wait cyc%0d: got %b want %b", i, ctl, exp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sw_wait();
    logic [16:0] exp [7] = '{E_FETCH_W, E_FETCH_W, E_FETCH_R, E_DECODE,
                             E_MEMADDR, E_MEMWR, E_MEMWR};
    logic        rdy [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    bus.opcode = OP_SW;
    for (int i = 0; i < 7; i++) begin
      bus.mem_ready = rdy[i];
      #1;
      checks++;
      if (ctl !== exp[i]) begin
        errors++;
        $display("FAIL sw_wait cyc%0d: got %b want %b", i, ctl, exp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_beq();
    logic [16:0] exp [6] = '{E_FETCH_R, E_DECODE, E_BR_Z1,
                             E_FETCH_R, E_DECODE, E_BR_Z0};
    logic        zf  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    bus.opcode    = OP_BEQ;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.zero = zf[i];
      #1;
      checks++;
      if (ctl !== exp[i]) begin
        errors++;
        $display("FAIL beq cyc%0d: got %b want %b", i, ctl, exp[i]);
      end
      @(negedge clk);
    end
    bus.zero = 1'b0;
  endtask

  task automatic test_jump();
    logic [16:0] exp [3] = '{E_FETCH_R, E_DECODE, E_JUMP};
    bus.opcode    = OP_J;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== exp[i]) begin
        errors++;
        $display("FAIL jump cyc%0d: got %b want %b", i, ctl, exp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_addi();
    logic [16:0] exp [4] = '{E_FETCH_R, E_DECODE, E_ADDIEX, E_ADDIWB};
    bus.opcode    = OP_ADDI;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (ctl !== exp[i]) begin
        errors++;
        $display("FAIL addi cyc%0d: got %b want %b", i, ctl, exp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_jal();
    logic [16:0] exp [3] = '{E_FETCH_R, E_DECODE, E_JAL};
    bus.opcode    = OP_JAL;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== exp[i]) begin
        errors++;
        $display("FAIL jal cyc%0d: got %b want %b", i, ctl, exp[i]);
      end
      @(negedge clk);
    end
  endtask

  // Illegal opcode, then j, addi and R-type; the flag must stick throughout.
  task automatic test_illegal();
    logic [16:0] exp [13] = '{E_FETCH_R, E_DECODE,
                              E_FETCH_R, E_DECODE, E_JUMP,
                              E_FETCH_R, E_DECODE, E_ADDIEX, E_ADDIWB,
                              E_FETCH_R, E_DECODE, E_EXEC, E_RWB};
    logic [5:0]  op  [13] = '{6'b111111, 6'b111111,
                              OP_J, OP_J, OP_J,
                              OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI,
                              OP_R, OP_R, OP_R, OP_R};
    logic        ill;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      bus.opcode = op[i];
      ill = (i >= 2);
      #1;
      checks++;
      if (ctl !== exp[i]) begin
        errors++;
        $display("FAIL illegal_seq cyc%0d: got %b want %b", i, ctl, exp[i]);
      end
      checks++;
      if (bus.illegal !== ill) begin
        errors++;
        $display("FAIL illegal_flag cyc%0d: got %b want %b", i, bus.illegal, ill);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [16:0] pre  [4] = '{E_FETCH_R, E_DECODE, E_MEMADDR, E_MEMWR};
    logic        rdy  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [16:0] post [4] = '{E_FETCH_R, E_DECODE, E_EXEC, E_RWB};
    bus.opcode = OP_SW;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = rdy[i];
      #1;
      checks++;
      if (ctl !== pre[i]) begin
        errors++;
        $display("FAIL rst_wait_pre cyc%0d: got %b want %b", i, ctl, pre[i]);
      end
      if (i < 3) @(negedge clk);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_write !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_mem_write: got %b want 0", bus.mem_write);
    end
    checks++;
    if (bus.illegal !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_illegal: got %b want 0", bus.illegal);
    end
    bus.mem_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (ctl !== E_ZERO) begin
      errors++;
      $display("FAIL rst_wait_held: got %b want %b", ctl, E_ZERO);
    end
    @(negedge clk);
    reset_n    = 1'b1;
    bus.opcode = OP_R;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (ctl !== post[i]) begin
        errors++;
        $display("FAIL rst_wait_post cyc%0d: got %b want %b", i, ctl, post[i]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_lw_wait();
    test_sw_wait();
    test_beq();
    test_jump();
    test_addi();
    test_jal();
    test_illegal();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
